// File: rtl/mem_bus_master.sv
// Initiator for the shared memory bus: turns CPU load/store requests into bus cycles.
// Drives on rising clk; the responder samples on falling clk. Sub-doubleword stores use read-modify-write.
module mem_bus_master #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter bit SUPPORT_RMW = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    output logic              rw,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, RMW_RD = 2'd2, WR = 2'd3} state_t;

    state_t            state;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [2:0]        lane_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic              err_pend;

    // Handshake: a request is taken when req_valid & req_ready are both high at a rising edge;
    // resp_valid is a single-cycle pulse with no backpressure.
    assign req_ready = (state == IDLE);
    assign dbg_state = state;
    assign data      = rw ? data_q : {DATA_W{1'bz}};

    logic [2:0]        align_mask;
    logic              misaligned;
    logic              bad_req;
    logic [5:0]        shamt;
    logic [DATA_W-1:0] size_mask;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] merged;

    always_comb begin
        align_mask = 3'b000;
        case (req_size)
            2'd0: align_mask = 3'b000;
            2'd1: align_mask = 3'b001;
            2'd2: align_mask = 3'b011;
            2'd3: align_mask = 3'b111;
        endcase
    end

    assign misaligned = |(req_addr[2:0] & align_mask);
    assign bad_req    = misaligned || (req_we && (req_size != 2'd3) && !SUPPORT_RMW);

    assign shamt   = {lane_q, 3'b000};
    assign shifted = data >> shamt;

    always_comb begin
        size_mask = {DATA_W{1'b1}};
        case (size_q)
            2'd0: size_mask = {{(DATA_W-8){1'b0}}, 8'hFF};
            2'd1: size_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
            2'd2: size_mask = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
            2'd3: size_mask = {DATA_W{1'b1}};
        endcase
    end

    always_comb begin
        load_val = shifted & size_mask;
        if (signed_q) begin
            case (size_q)
                2'd0: load_val = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
                2'd1: load_val = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
                2'd2: load_val = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
                2'd3: load_val = shifted;
            endcase
        end
    end

    // Only the addressed lanes take store bytes; the rest keep the word just read.
    assign merged = (data & ~(size_mask << shamt)) | ((wdata_q & size_mask) << shamt);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            addr       <= '0;
            rw         <= 1'b0;
            data_q     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            err_pend   <= 1'b0;
            size_q     <= 2'd0;
            signed_q   <= 1'b0;
            lane_q     <= 3'd0;
            wdata_q    <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (state)
                IDLE: begin
                    // Errors are answered one cycle after accept, like every other request.
                    if (err_pend) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end
                    err_pend <= 1'b0;
                    if (req_valid) begin
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        lane_q   <= req_addr[2:0];
                        wdata_q  <= req_wdata;
                        if (bad_req) begin
                            err_pend <= 1'b1;
                        end else begin
                            addr <= {req_addr[ADDR_W-1:3], 3'b000};
                            if (!req_we) begin
                                state <= RD;
                            end else if (req_size == 2'd3) begin
                                rw     <= 1'b1;
                                data_q <= req_wdata;
                                state  <= WR;
                            end else begin
                                state <= RMW_RD;
                            end
                        end
                    end
                end
                RD: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_val;
                    state      <= IDLE;
                end
                RMW_RD: begin
                    data_q <= merged;
                    rw     <= 1'b1;
                    state  <= WR;
                end
                WR: begin
                    rw         <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: table vectors, hand-written multi-cycle sequences and random
// requests checked against a byte-array memory model; a falling-edge responder serves the bus.
module tb_mem_bus_master;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] addr;
    wire  [63:0] data;
    logic        rw;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_master dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .addr(addr), .data(data), .rw(rw), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // responder: 16 words, reads latched and writes committed on the falling edge
    logic [63:0] mem [0:15];
    logic [63:0] mem_q;
    logic        ld_en;
    logic [3:0]  ld_idx;
    logic [63:0] ld_val;

    assign data = rw ? 64'bz : mem_q;

    always @(negedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_val;
        else if (rw) mem[addr[6:3]] <= data;
        else mem_q <= mem[addr[6:3]];
    end

    // reference model: byte-addressed memory, little-endian
    logic [7:0]  ref_mem [0:127];
    logic [64:0] exp_q [$];

    function automatic logic [64:0] model(input logic we, input logic [1:0] size, input logic sgn,
                                          input logic [6:0] a, input logic [63:0] wd);
        int n;
        logic [63:0] v;
        n = 1 << size;
        v = 64'd0;
        if ((int'(a) % n) != 0) return {1'b1, 64'd0};
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            return 65'd0;
        end
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8*i));
        if (sgn && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return {1'b0, v};
    endfunction

    function automatic logic [63:0] ref_word(input int w);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[8*w + i];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: issue one request, then watch the bus until the response pulse
    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [6:0] a, input logic [63:0] wd,
                           output int lat, output logic err, output logic [63:0] rd,
                           output logic saw_wr, output logic addr_moved);
        logic [63:0] addr0;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_wait", {63'd0, req_ready}, 64'd1);
        addr0      = addr;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = {57'd0, a};
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = {$urandom, $urandom};
        req_wdata  = {$urandom, $urandom};
        lat = -1; err = 1'b0; rd = 64'd0; saw_wr = 1'b0; addr_moved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rw) saw_wr = 1'b1;
            if (addr !== addr0) addr_moved = 1'b1;
            if (resp_valid) begin
                lat = i;
                err = resp_err;
                rd  = resp_rdata;
                break;
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [6:0]  a;
        logic [63:0] wd;
        logic        err;
        logic [63:0] rd;
        int          lat;
    } vec_t;

    vec_t vecs [17];

    initial begin
        int lat;
        logic err, saw_wr, addr_moved;
        logic [63:0] rd, v;
        logic [64:0] e;
        logic [1:0] sz;
        logic [6:0] a;
        logic we, sgn;
        int seen;

        vecs[0]  = '{1'b0, 2'd3, 1'b0, 7'h10, 64'd0,                  1'b0, 64'h1122334455667788, 1};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 7'h17, 64'd0,                  1'b0, 64'h0000000000000011, 1};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 7'h10, 64'd0,                  1'b0, 64'hFFFFFFFFFFFFFF88, 1};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 7'h10, 64'd0,                  1'b0, 64'h0000000000000088, 1};
        vecs[4]  = '{1'b1, 2'd0, 1'b0, 7'h12, 64'hFFFFFFFFFFFFFFAB,   1'b0, 64'd0,                2};
        vecs[5]  = '{1'b0, 2'd3, 1'b0, 7'h10, 64'd0,                  1'b0, 64'h1122334455AB7788, 1};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 7'h06, 64'd0,                  1'b1, 64'd0,                1};
        vecs[7]  = '{1'b1, 2'd2, 1'b0, 7'h18, 64'h0000000180000001,   1'b0, 64'd0,                2};
        vecs[8]  = '{1'b0, 2'd2, 1'b1, 7'h18, 64'd0,                  1'b0, 64'hFFFFFFFF80000001, 1};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 7'h18, 64'd0,                  1'b0, 64'h0000000080000001, 1};
        vecs[10] = '{1'b1, 2'd3, 1'b0, 7'h06, 64'h1234,               1'b1, 64'd0,                1};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 7'h1E, 64'h000000000000BEEF,   1'b0, 64'd0,                2};
        vecs[12] = '{1'b0, 2'd1, 1'b1, 7'h1E, 64'd0,                  1'b0, 64'hFFFFFFFFFFFFBEEF, 1};
        vecs[13] = '{1'b0, 2'd3, 1'b0, 7'h18, 64'd0,                  1'b0, 64'hBEEF000080000001, 1};
        vecs[14] = '{1'b1, 2'd3, 1'b0, 7'h10, 64'h0123456789ABCDEF,   1'b0, 64'd0,                1};
        vecs[15] = '{1'b0, 2'd1, 1'b0, 7'h11, 64'd0,                  1'b1, 64'd0,                1};
        vecs[16] = '{1'b0, 2'd1, 1'b0, 7'h16, 64'd0,                  1'b0, 64'h0000000000000123, 1};

        resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 64'd0; req_wdata = 64'd0;
        ld_en = 1'b1; ld_idx = 4'd0; ld_val = 64'd0;

        // preload memory and model identically while held in reset
        for (int w = 0; w < 16; w++) begin
            v = {$urandom, $urandom};
            if (w == 2) v = 64'h1122334455667788;
            if (w == 3) v = 64'd0;
            for (int i = 0; i < 8; i++) ref_mem[8*w + i] = v[8*i +: 8];
            @(posedge clk);
            ld_idx = 4'(w);
            ld_val = v;
        end
        @(posedge clk);
        ld_en = 1'b0;

        #1;
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", {63'd0, resp_err}, 64'd0);
        check("rst_addr", addr, 64'd0);
        check("rst_rw", {63'd0, rw}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // table vectors
        foreach (vecs[k]) begin
            e = model(vecs[k].we, vecs[k].size, vecs[k].sgn, vecs[k].a, vecs[k].wd);
            run_req(vecs[k].we, vecs[k].size, vecs[k].sgn, vecs[k].a, vecs[k].wd,
                    lat, err, rd, saw_wr, addr_moved);
            check($sformatf("vec%0d_latency", k), 64'(lat), 64'(vecs[k].lat));
            check($sformatf("vec%0d_err", k), {63'd0, err}, {63'd0, vecs[k].err});
            check($sformatf("vec%0d_rdata", k), rd, vecs[k].rd);
            if (!vecs[k].we || vecs[k].err)
                check($sformatf("vec%0d_no_write", k), {63'd0, saw_wr}, 64'd0);
            if (vecs[k].err)
                check($sformatf("vec%0d_addr_held", k), {63'd0, addr_moved}, 64'd0);
        end

        // back-to-back: double store then load held on req_valid
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_signed = 1'b0;
        req_addr = 64'h20; req_wdata = 64'hDEADBEEFCAFEF00D;
        e = model(1'b1, 2'd3, 1'b0, 7'h20, 64'hDEADBEEFCAFEF00D);
        @(posedge clk);
        #1;
        req_we = 1'b0; req_wdata = 64'h0;
        @(negedge clk);
        check("b2b_busy_ready", {63'd0, req_ready}, 64'd0);
        check("b2b_write_rw", {63'd0, rw}, 64'd1);
        @(negedge clk);
        check("b2b_store_resp", {63'd0, resp_valid}, 64'd1);
        check("b2b_ready_with_resp", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_pulse_one_cycle", {63'd0, resp_valid}, 64'd0);
        check("b2b_load_rw", {63'd0, rw}, 64'd0);
        @(negedge clk);
        check("b2b_load_resp", {63'd0, resp_valid}, 64'd1);
        check("b2b_load_rdata", resp_rdata, 64'hDEADBEEFCAFEF00D);

        // reset during RMW_RD: the byte store to word 5 is dropped
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 64'h28; req_wdata = 64'h5A;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rmw_busy_ready", {63'd0, req_ready}, 64'd0);
        #2;
        resetn = 1'b0;
        #1;
        check("rmw_rst_rw", {63'd0, rw}, 64'd0);
        check("rmw_rst_ready", {63'd0, req_ready}, 64'd1);
        check("rmw_rst_resp", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("rmw_rst_no_resp", 64'(seen), 64'd0);

        // reset during WR before the falling edge: the double store to word 6 is dropped
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_addr = 64'h30; req_wdata = {$urandom, $urandom};
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("wr_rw_high", {63'd0, rw}, 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("wr_rst_rw", {63'd0, rw}, 64'd0);
        check("wr_rst_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        resetn = 1'b1;

        e = model(1'b0, 2'd3, 1'b0, 7'h28, 64'd0);
        run_req(1'b0, 2'd3, 1'b0, 7'h28, 64'd0, lat, err, rd, saw_wr, addr_moved);
        check("rmw_rst_word_unchanged", rd, e[63:0]);
        e = model(1'b0, 2'd3, 1'b0, 7'h30, 64'd0);
        run_req(1'b0, 2'd3, 1'b0, 7'h30, 64'd0, lat, err, rd, saw_wr, addr_moved);
        check("wr_rst_word_unchanged", rd, e[63:0]);

        // random requests against the model, through the expected queue
        for (int k = 0; k < 150; k++) begin
            we  = 1'($urandom);
            sz  = 2'($urandom_range(0, 3));
            sgn = 1'($urandom);
            a   = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) a = a & ~7'((1 << sz) - 1);
            v = {$urandom, $urandom};
            exp_q.push_back(model(we, sz, sgn, a, v));
            run_req(we, sz, sgn, a, v, lat, err, rd, saw_wr, addr_moved);
            e = exp_q.pop_front();
            check($sformatf("rnd%0d_latency", k), 64'(lat),
                  (e[64] || !we || sz == 2'd3) ? 64'd1 : 64'd2);
            check($sformatf("rnd%0d_err", k), {63'd0, err}, {63'd0, e[64]});
            check($sformatf("rnd%0d_rdata", k), rd, e[63:0]);
        end

        @(negedge clk);
        @(negedge clk);
        for (int w = 0; w < 16; w++)
            check($sformatf("mem_word%0d", w), mem[w], ref_word(w));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
